ecc_decode_pipe: RTL and testbench
==================================

Name: ecc_decode_pipe

Overview:
- Read-path counterpart of the block-RAM write-side ECC encoder.
- Consumes one 39-bit SEC-DED codeword per cycle as read from a 40-bit-wide RAM half (bits [19:0] from the lower port word, bits [38:20] from the upper port word).
- Corrects single-bit errors and flags double-bit errors.
- Keeps sticky flags, saturating error counters and the address of the first failing read for the configuration/readback interface.

Parameters:
- OUT_REG, 1, 1 adds a registered output stage (latency 2); 0 gives latency 1.
- CNT_W, 8, width of the saturating error counters.
- ADDR_W, 16, width of the captured read address.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ecc_en_i  in  1  1: decode/correct; 0: raw bypass.
- rd_valid_i  in  1  codeword_i/rd_addr_i valid this cycle.
- rd_addr_i  in  ADDR_W  address of the read.
- codeword_i  in  39  stored codeword.
- clr_i  in  1  clears sticky flags, counters and captured address.
- rd_valid_o  out  1  data_o valid.
- data_o  out  32  corrected data.
- sbe_o  out  1  single-bit error corrected on this output beat.
- dbe_o  out  1  uncorrectable error on this output beat.
- sbe_sticky_o  out  1  any SBE since reset/clear.
- dbe_sticky_o  out  1  any DBE since reset/clear.
- sbe_cnt_o  out  CNT_W  saturating SBE count.
- dbe_cnt_o  out  CNT_W  saturating DBE count.
- err_addr_o  out  ADDR_W  address of the first error (SBE or DBE) since reset/clear.

Behaviour:
- Code layout:
  - Codeword bit i (0..37) is Hamming position i+1.
  - Parity bits sit at positions 1, 2, 4, 8, 16, 32.
  - Data bits d0..d31 fill the remaining positions 3, 5, 6, 7, 9, ... in ascending order.
  - Bit 38 is overall even parity over bits 0..37.
- Syndrome and overall check:
  - s[k] (k=0..5) = XOR of bits whose position has bit k set, including the parity bit itself.
  - p = XOR of all 39 bits.
- Classification:
  - s=0, p=0: clean.
  - p=1, s=0: error in bit 38; data unchanged; SBE.
  - p=1, 1<=s<=38: flip codeword bit s-1; SBE.
  - p=1, s>38: DBE.
  - p=0, s!=0: DBE; data_o carries the uncorrected extracted data.
- Pipeline and latency:
  - Stage 1 registers the syndrome, p, the extracted raw data, rd_addr_i and rd_valid_i.
  - Correction is applied combinationally from the stage-1 registers.
  - OUT_REG=1 registers the corrected data and flags again.
  - Result appears OUT_REG+1 cycles after rd_valid_i; one result per cycle, no stall.
- Outputs when rd_valid_o=0: data_o holds its last value; sbe_o and dbe_o are 0.
- Bypass (ecc_en_i=0):
  - data_o = codeword_i[31:0]; sbe_o and dbe_o = 0; no sticky or counter update.
  - ecc_en_i is sampled with the beat in stage 1, so a mid-stream toggle affects only new beats.
- Sticky/counter updates:
  - Happen on the cycle sbe_o/dbe_o is asserted.
  - Counters saturate at all-ones with no wrap.
  - err_addr_o loads only when no error is captured since reset/clear.
- clr_i:
  - Clears sticky flags, counters and the address-captured state.
  - A clr_i coincident with an error output: the clear applies first, then the error. Result: sticky=1, counter=1, err_addr_o = that beat's address.
  - clr_i does not affect in-flight data.
- Reset (rst_i=1) clears all outputs and pipeline registers to 0 regardless of in-flight beats. Beats accepted during reset are dropped. The first beat after reset deassertion is processed normally.

Test Plan:
- Codeword 39'h0, valid, addr 16'h0010, OUT_REG=1 -> two cycles later data_o=0, rd_valid_o=1, sbe_o=0, dbe_o=0.
- Zero codeword with bit 2 flipped (d0 position 3), addr 16'h0020 -> data_o=0, sbe_o=1, sbe_sticky_o=1, sbe_cnt_o=1, err_addr_o=16'h0020.
- Zero codeword with bits 0 and 1 flipped, addr 16'h0030, after an earlier SBE -> dbe_o=1, dbe_cnt_o=1, err_addr_o stays at the first error address.
- Zero codeword with only bit 38 flipped -> sbe_o=1, data_o=0. Then 300 consecutive SBE beats with CNT_W=8 -> sbe_cnt_o=8'hFF, no wrap.
- clr_i asserted on the same cycle an SBE beat exits at addr 16'h0040 -> sbe_sticky_o=1, sbe_cnt_o=1, err_addr_o=16'h0040, dbe_sticky_o=0.
- Beat in flight when rst_i pulses for 1 cycle -> rd_valid_o=0 and all counters 0 after reset. With ecc_en_i=0, codeword 39'h7F_1234_5678 -> data_o=32'h12345678, sbe_o=0.

Source files
------------

// File: rtl/ecc_decode_pipe_if.sv
// ecc_decode_pipe_if: read-beat bus (ecc_en/rd_valid/rd_addr/codeword/clr in; decoded data, error flags, sticky status, counters, first-error address out)
interface ecc_decode_pipe_if #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 16
);
  logic              ecc_en_i;
  logic              rd_valid_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [38:0]       codeword_i;
  logic              clr_i;
  logic              rd_valid_o;
  logic [31:0]       data_o;
  logic              sbe_o;
  logic              dbe_o;
  logic              sbe_sticky_o;
  logic              dbe_sticky_o;
  logic [CNT_W-1:0]  sbe_cnt_o;
  logic [CNT_W-1:0]  dbe_cnt_o;
  logic [ADDR_W-1:0] err_addr_o;
  modport master (
    output ecc_en_i, rd_valid_i, rd_addr_i, codeword_i, clr_i,
    input  rd_valid_o, data_o, sbe_o, dbe_o, sbe_sticky_o, dbe_sticky_o, sbe_cnt_o, dbe_cnt_o, err_addr_o
  );
  modport slave (
    input  ecc_en_i, rd_valid_i, rd_addr_i, codeword_i, clr_i,
    output rd_valid_o, data_o, sbe_o, dbe_o, sbe_sticky_o, dbe_sticky_o, sbe_cnt_o, dbe_cnt_o, err_addr_o
  );
endinterface

// File: rtl/ecc_decode_pipe.sv
// ecc_decode_pipe: SEC-DED (39,32) read-path decoder; ports clk_i, rst_i (sync high), bus (slave: beat in, corrected data/flags/sticky/counters/first-error address out)
module ecc_decode_pipe #(
  parameter int OUT_REG = 1,
  parameter int CNT_W   = 8,
  parameter int ADDR_W  = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  ecc_decode_pipe_if.slave bus
);
  function automatic logic [5:0] syndrome(input logic [37:0] c);
    logic [5:0] s;
    s = '0;
    for (int i = 1; i <= 38; i++) s = c[6'(i - 1)] ? s ^ 6'(i) : s;
    return s;
  endfunction
  function automatic logic [31:0] extract(input logic [38:0] c);
    logic [31:0] d;
    logic [5:0]  k;
    d = '0;
    k = '0;
    for (int i = 1; i <= 38; i++)
      if ((i & (i - 1)) != 0) begin
        d[k[4:0]] = c[6'(i - 1)];
        k = k + 6'd1;
      end
    return d;
  endfunction
  // data-bit mask for a syndrome; parity positions and out-of-range syndromes give 0
  function automatic logic [31:0] flip(input logic [5:0] s);
    logic [31:0] m;
    logic [5:0]  k;
    m = '0;
    k = '0;
    for (int i = 1; i <= 38; i++)
      if ((i & (i - 1)) != 0) begin
        m[k[4:0]] = (s == 6'(i));
        k = k + 6'd1;
      end
    return m;
  endfunction
  logic              s1_v, s1_en, s1_p;
  logic [5:0]        s1_syn;
  logic [31:0]       s1_raw;
  logic [ADDR_W-1:0] s1_addr;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v    <= 1'b0;
      s1_en   <= 1'b0;
      s1_p    <= 1'b0;
      s1_syn  <= '0;
      s1_raw  <= '0;
      s1_addr <= '0;
    end else begin
      s1_v <= bus.rd_valid_i;
      // payload only loads on a valid beat so data_o holds between beats
      if (bus.rd_valid_i) begin
        s1_en   <= bus.ecc_en_i;
        s1_p    <= ^bus.codeword_i;
        s1_syn  <= syndrome(bus.codeword_i[37:0]);
        s1_raw  <= bus.ecc_en_i ? extract(bus.codeword_i) : bus.codeword_i[31:0];
        s1_addr <= bus.rd_addr_i;
      end
    end
  end
  logic        c_sbe, c_dbe;
  logic [31:0] c_data;
  always_comb begin
    c_sbe  = s1_v & s1_en & s1_p & (s1_syn <= 6'd38);
    c_dbe  = s1_v & s1_en & (s1_p ? (s1_syn > 6'd38) : (s1_syn != 6'd0));
    c_data = s1_raw ^ ((s1_en & s1_p) ? flip(s1_syn) : 32'd0);
  end
  logic              o_v, o_sbe, o_dbe;
  logic [31:0]       o_data;
  logic [ADDR_W-1:0] o_addr;
  if (OUT_REG != 0) begin : g_reg
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        o_v    <= 1'b0;
        o_sbe  <= 1'b0;
        o_dbe  <= 1'b0;
        o_data <= '0;
        o_addr <= '0;
      end else begin
        o_v   <= s1_v;
        o_sbe <= c_sbe;
        o_dbe <= c_dbe;
        if (s1_v) begin
          o_data <= c_data;
          o_addr <= s1_addr;
        end
      end
    end
  end else begin : g_comb
    assign o_v    = s1_v;
    assign o_sbe  = c_sbe;
    assign o_dbe  = c_dbe;
    assign o_data = c_data;
    assign o_addr = s1_addr;
  end
  logic              sbe_st, dbe_st, cap;
  logic [CNT_W-1:0]  sbe_cnt, dbe_cnt;
  logic [ADDR_W-1:0] err_addr;
  logic              cap_kept;
  // clear takes effect before a coincident error so that error is captured fresh
  assign cap_kept = cap & ~bus.clr_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sbe_st   <= 1'b0;
      dbe_st   <= 1'b0;
      cap      <= 1'b0;
      sbe_cnt  <= '0;
      dbe_cnt  <= '0;
      err_addr <= '0;
    end else begin
      sbe_st  <= (sbe_st & ~bus.clr_i) | o_sbe;
      dbe_st  <= (dbe_st & ~bus.clr_i) | o_dbe;
      cap     <= cap_kept | o_sbe | o_dbe;
      sbe_cnt <= bus.clr_i ? CNT_W'(o_sbe) : sbe_cnt + CNT_W'(o_sbe & ~&sbe_cnt);
      dbe_cnt <= bus.clr_i ? CNT_W'(o_dbe) : dbe_cnt + CNT_W'(o_dbe & ~&dbe_cnt);
      if ((o_sbe | o_dbe) & ~cap_kept) err_addr <= o_addr;
      else if (bus.clr_i) err_addr <= '0;
    end
  end
  assign bus.rd_valid_o   = o_v;
  assign bus.data_o       = o_data;
  assign bus.sbe_o        = o_sbe;
  assign bus.dbe_o        = o_dbe;
  assign bus.sbe_sticky_o = sbe_st;
  assign bus.dbe_sticky_o = dbe_st;
  assign bus.sbe_cnt_o    = sbe_cnt;
  assign bus.dbe_cnt_o    = dbe_cnt;
  assign bus.err_addr_o   = err_addr;
endmodule

// File: tb/tb_ecc_decode_pipe.sv
// tb_ecc_decode_pipe: randomized and directed checks of ecc_decode_pipe against a flip-injection reference model
module tb_ecc_decode_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ecc_decode_pipe_if #(.CNT_W(8), .ADDR_W(16)) bus ();
  ecc_decode_pipe #(.OUT_REG(1), .CNT_W(8), .ADDR_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic        p_v, p_s, p_db;
  logic [31:0] p_d;
  logic [15:0] p_a;
  logic        m1_v, m1_s, m1_db, mo_v, mo_s, mo_db;
  logic [31:0] m1_d, mo_d;
  logic [15:0] m1_a, mo_a, m_addr;
  logic        ms_s, ms_d, m_cap;
  int          mc_s, mc_d;
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] c;
    int k;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    for (int j = 0; j < 6; j++)
      for (int pos = 1; pos <= 38; pos++)
        if (((pos >> j) & 1) == 1 && pos != (1 << j)) c[(1 << j) - 1] ^= c[pos-1];
    c[38] = ^c[37:0];
    return c;
  endfunction
  function automatic logic [31:0] ext(input logic [38:0] c);
    logic [31:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos-1];
        k++;
      end
    return d;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      {m1_v, m1_s, m1_db, mo_v, mo_s, mo_db, ms_s, ms_d, m_cap} = '0;
      {m1_d, mo_d, m1_a, mo_a, m_addr} = '0;
      mc_s = 0;
      mc_d = 0;
    end else begin
      if (bus.clr_i) begin
        {ms_s, ms_d, m_cap} = '0;
        m_addr = '0;
        mc_s = 0;
        mc_d = 0;
      end
      if (mo_s) begin
        ms_s = 1'b1;
        mc_s = (mc_s < 255) ? mc_s + 1 : 255;
      end
      if (mo_db) begin
        ms_d = 1'b1;
        mc_d = (mc_d < 255) ? mc_d + 1 : 255;
      end
      if ((mo_s || mo_db) && !m_cap) begin
        m_addr = mo_a;
        m_cap = 1'b1;
      end
      mo_v = m1_v;
      mo_s = m1_s;
      mo_db = m1_db;
      if (m1_v) begin
        mo_d = m1_d;
        mo_a = m1_a;
      end
      {m1_v, m1_s, m1_db, m1_d, m1_a} = {p_v, p_s, p_db, p_d, p_a};
    end
    #1;
    chk("rd_valid", 64'(bus.rd_valid_o), 64'(mo_v));
    chk("data", 64'(bus.data_o), 64'(mo_d));
    chk("sbe", 64'(bus.sbe_o), 64'(mo_s));
    chk("dbe", 64'(bus.dbe_o), 64'(mo_db));
    chk("sbe_sticky", 64'(bus.sbe_sticky_o), 64'(ms_s));
    chk("dbe_sticky", 64'(bus.dbe_sticky_o), 64'(ms_d));
    chk("sbe_cnt", 64'(bus.sbe_cnt_o), 64'(mc_s));
    chk("dbe_cnt", 64'(bus.dbe_cnt_o), 64'(mc_d));
    chk("err_addr", 64'(bus.err_addr_o), 64'(m_addr));
  endtask
  task automatic drive(input logic v, input logic en, input logic [15:0] a, input logic [38:0] cw,
                       input logic [31:0] ed, input logic es, input logic edb);
    bus.rd_valid_i = v;
    bus.ecc_en_i = en;
    bus.rd_addr_i = a;
    bus.codeword_i = cw;
    p_v = v;
    p_d = ed;
    p_s = v & en & es;
    p_db = v & en & edb;
    p_a = a;
    cyc();
  endtask
  task automatic idle();
    drive(1'b0, 1'b1, 16'h0, 39'h0, 32'h0, 1'b0, 1'b0);
  endtask
  // nf flips at distinct bits b0/b1: one flip is always corrected, two are always flagged
  task automatic beat(input logic [31:0] d, input int nf, input int b0, input int b1, input logic [15:0] a);
    logic [38:0] cw;
    cw = enc(d);
    if (nf > 0) cw[b0] = ~cw[b0];
    if (nf > 1) cw[b1] = ~cw[b1];
    drive(1'b1, 1'b1, a, cw, (nf == 2) ? ext(cw) : d, nf == 1, nf == 2);
  endtask
  initial begin
    logic [38:0] cw;
    int nf, b0;
    bus.clr_i = 1'b0;
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    chk("reset_valid", 64'(bus.rd_valid_o), 64'd0);
    chk("reset_data", 64'(bus.data_o), 64'd0);
    chk("reset_cnt", 64'(bus.sbe_cnt_o), 64'd0);
    beat(32'h0, 0, 0, 0, 16'h0010);
    idle();
    chk("clean_valid", 64'(bus.rd_valid_o), 64'd1);
    chk("clean_sbe", 64'(bus.sbe_o), 64'd0);
    beat(32'h0, 1, 2, 0, 16'h0020);
    idle();
    chk("sbe_d0_flag", 64'(bus.sbe_o), 64'd1);
    chk("sbe_d0_data", 64'(bus.data_o), 64'd0);
    idle();
    chk("sbe_d0_cnt", 64'(bus.sbe_cnt_o), 64'd1);
    chk("sbe_d0_addr", 64'(bus.err_addr_o), 64'h20);
    beat(32'h0, 2, 0, 1, 16'h0030);
    idle();
    chk("dbe_flag", 64'(bus.dbe_o), 64'd1);
    idle();
    chk("dbe_cnt", 64'(bus.dbe_cnt_o), 64'd1);
    chk("dbe_keep_addr", 64'(bus.err_addr_o), 64'h20);
    beat(32'h0, 1, 38, 0, 16'h0050);
    idle();
    chk("sbe_b38_flag", 64'(bus.sbe_o), 64'd1);
    chk("sbe_b38_data", 64'(bus.data_o), 64'd0);
    for (int i = 0; i < 300; i++)
      beat($urandom, 1, $urandom_range(0, 38), 0, 16'($urandom));
    idle();
    idle();
    idle();
    chk("sbe_saturate", 64'(bus.sbe_cnt_o), 64'hFF);
    for (int i = 0; i < 300; i++) begin
      bus.clr_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) idle();
      else if ($urandom_range(0, 4) == 0) begin
        cw = {7'($urandom), 32'($urandom)};
        drive(1'b1, 1'b0, 16'($urandom), cw, cw[31:0], 1'b0, 1'b0);
      end else begin
        nf = $urandom_range(0, 2);
        b0 = $urandom_range(0, 38);
        beat($urandom, nf, b0, (b0 + $urandom_range(1, 38)) % 39, 16'($urandom));
      end
    end
    bus.clr_i = 1'b1;
    idle();
    bus.clr_i = 1'b0;
    beat(32'h0, 1, 2, 0, 16'h0040);
    idle();
    bus.clr_i = 1'b1;
    idle();
    bus.clr_i = 1'b0;
    chk("clr_sbe_sticky", 64'(bus.sbe_sticky_o), 64'd1);
    chk("clr_sbe_cnt", 64'(bus.sbe_cnt_o), 64'd1);
    chk("clr_err_addr", 64'(bus.err_addr_o), 64'h40);
    chk("clr_dbe_sticky", 64'(bus.dbe_sticky_o), 64'd0);
    beat(32'hDEADBEEF, 1, 5, 0, 16'h0070);
    rst = 1'b1;
    beat(32'hCAFEF00D, 2, 3, 9, 16'h0080);
    rst = 1'b0;
    idle();
    idle();
    chk("rst_drop_valid", 64'(bus.rd_valid_o), 64'd0);
    chk("rst_sbe_cnt", 64'(bus.sbe_cnt_o), 64'd0);
    chk("rst_dbe_cnt", 64'(bus.dbe_cnt_o), 64'd0);
    cw = 39'h7F_1234_5678;
    drive(1'b1, 1'b0, 16'h0060, cw, 32'h12345678, 1'b0, 1'b0);
    idle();
    chk("bypass_data", 64'(bus.data_o), 64'h12345678);
    chk("bypass_sbe", 64'(bus.sbe_o), 64'd0);
    idle();
    chk("bypass_no_sticky", 64'(bus.sbe_sticky_o), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
